// File: rtl/output_port_alloc.sv
// Output-port allocator: round-robin arbitration over five input ports with
// credit-based flow control toward the downstream router.
// Optional wormhole packet locking is enabled by defining OPA_PKT_LOCK_EN;
// without it every flit is arbitrated independently and busy_o stays low.
//
// state  | meaning
// IDLE   | free; winner chosen round-robin starting at ptr
// LOCKED | held by input "holder" until the packet's last flit is forwarded
module output_port_alloc #(
  parameter int CREDIT_MAX = 4,
  parameter int PKT_LEN    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] req_i,
  input  logic       credit_i,
  output logic [4:0] read_o,
  output logic [2:0] mux_sel_o,
  output logic       valid_o,
  output logic [2:0] credit_cnt_o,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

`ifdef OPA_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam logic [2:0] CMAX     = 3'(CREDIT_MAX);
  localparam logic [3:0] REM_INIT = 4'(PKT_LEN - 1);
  localparam logic [2:0] NONE     = 3'd7;

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [2:0] holder, holder_nx;
  logic [3:0] rem, rem_nx;
  logic [2:0] cnt, cnt_nx;
  logic       err, err_nx;
  logic       found;
  logic [2:0] win;
  logic       fire;

  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p >= 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  // Winner selection: round-robin scan in IDLE, holder only in LOCKED.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    found = 1'b0;
    win   = 3'd0;
    sum   = 4'd0;
    idx   = 3'd0;
    if (state == IDLE) begin
      for (int k = 0; k < 5; k++) begin
        sum = {1'b0, ptr} + 4'(k);
        if (sum >= 4'd5) sum = sum - 4'd5;
        idx = sum[2:0];
        if (!found && req_i[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end else if (req_i[holder]) begin
      found = 1'b1;
      win   = holder;
    end
    fire      = found && (cnt != 3'd0) && !reset;
    valid_o   = fire;
    read_o    = fire ? (5'd1 << win) : 5'd0;
    mux_sel_o = fire ? win : NONE;
  end

  // Next-state: lock/unlock, pointer advance, credit accounting.
  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    holder_nx = holder;
    rem_nx    = rem;
    cnt_nx    = cnt;
    err_nx    = err;
    if (fire) begin
      if (state == IDLE) begin
        if (LOCK_EN && PKT_LEN > 1) begin
          state_nx  = LOCKED;
          holder_nx = win;
          rem_nx    = REM_INIT;
        end else begin
          ptr_nx = next_port(win);
        end
      end else begin
        rem_nx = rem - 4'd1;
        if (rem == 4'd1) begin
          state_nx = IDLE;
          ptr_nx   = next_port(holder);
        end
      end
    end
    if (fire && !credit_i) begin
      cnt_nx = cnt - 3'd1;
    end else if (!fire && credit_i) begin
      // A credit arriving with the counter full is a protocol error upstream.
      if (cnt == CMAX) err_nx = 1'b1;
      else cnt_nx = cnt + 3'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 3'd0;
      holder <= 3'd0;
      rem    <= 4'd0;
      cnt    <= CMAX;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      holder <= holder_nx;
      rem    <= rem_nx;
      cnt    <= cnt_nx;
      err    <= err_nx;
    end
  end

  assign credit_cnt_o = cnt;
  assign err_o        = err;

`ifdef OPA_PKT_LOCK_EN
  assign busy_o = (state == LOCKED) && !reset;
`else
  assign busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_alloc.sv
// Scoreboard bench for output_port_alloc (CREDIT_MAX=4, PKT_LEN=4).
// Expectations follow OPA_PKT_LOCK_EN: locked-packet behaviour when defined,
// per-flit round-robin when not.
module tb_output_port_alloc;

`ifdef OPA_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] req_i = 5'd0;
  logic       credit_i = 1'b0;
  logic [4:0] read_o;
  logic [2:0] mux_sel_o;
  logic       valid_o;
  logic [2:0] credit_cnt_o;
  logic       busy_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       v;
    bit [2:0] s;
    bit [2:0] c;
    bit       chkc;
    bit       b;
    bit       e;
    string    nm;
  } exp_t;

  exp_t q[$];

  output_port_alloc #(.CREDIT_MAX(4), .PKT_LEN(4)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .credit_i(credit_i),
    .read_o(read_o), .mux_sel_o(mux_sel_o), .valid_o(valid_o),
    .credit_cnt_o(credit_cnt_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus and queue the expected response for it.
  task automatic cyc(input bit rst, input bit [4:0] req, input bit cr,
                     input bit v, input bit [2:0] s, input bit [2:0] c,
                     input bit chkc, input bit b, input bit e, input string nm);
    exp_t x;
    reset = rst; req_i = req; credit_i = cr;
    x.v = v; x.s = s; x.c = c; x.chkc = chkc; x.b = b; x.e = e; x.nm = nm;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1, 5'b11111, 0, 0, 3'd7, 3'd0, 0, 0, 0, "rst_a");
    cyc(1, 5'b11111, 0, 0, 3'd7, 3'd4, 1, 0, 0, "rst_b");
  endtask

  // Monitor: compare the DUT against the oldest expectation each cycle.
  initial begin
    exp_t x;
    logic [4:0] rd;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x  = q.pop_front();
        rd = x.v ? (5'd1 << x.s) : 5'd0;
        checks++;
        if (valid_o !== x.v) begin
          errors++;
          $display("FAIL %s valid_o got %b want %b", x.nm, valid_o, x.v);
        end
        checks++;
        if (mux_sel_o !== x.s) begin
          errors++;
          $display("FAIL %s mux_sel_o got %0d want %0d", x.nm, mux_sel_o, x.s);
        end
        checks++;
        if (read_o !== rd) begin
          errors++;
          $display("FAIL %s read_o got %b want %b", x.nm, read_o, rd);
        end
        checks++;
        if (busy_o !== x.b) begin
          errors++;
          $display("FAIL %s busy_o got %b want %b", x.nm, busy_o, x.b);
        end
        checks++;
        if (err_o !== x.e) begin
          errors++;
          $display("FAIL %s err_o got %b want %b", x.nm, err_o, x.e);
        end
        if (x.chkc) begin
          checks++;
          if (credit_cnt_o !== x.c) begin
            errors++;
            $display("FAIL %s credit_cnt_o got %0d want %0d", x.nm, credit_cnt_o, x.c);
          end
        end
      end
    end
  end

  initial begin
    int budget;
    @(posedge clk);
    #1;

    // Single requester N, no credits: four flits then credit exhaustion.
    do_reset();
    cyc(0, 5'b00001, 0, 1, 3'd0, 3'd4, 1, 0,    0, "drain0");
    cyc(0, 5'b00001, 0, 1, 3'd0, 3'd3, 1, LOCK, 0, "drain1");
    cyc(0, 5'b00001, 0, 1, 3'd0, 3'd2, 1, LOCK, 0, "drain2");
    cyc(0, 5'b00001, 0, 1, 3'd0, 3'd1, 1, LOCK, 0, "drain3");
    cyc(0, 5'b00001, 0, 0, 3'd7, 3'd0, 1, 0,    0, "drain_empty0");
    cyc(0, 5'b00001, 0, 0, 3'd7, 3'd0, 1, 0,    0, "drain_empty1");

    // All requesting, credit returned every cycle.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      if (LOCK)
        cyc(0, 5'b11111, 1, 1, 3'((i / 4) % 5), 3'd4, 1, (i % 4) != 0, 0, "rr_all");
      else
        cyc(0, 5'b11111, 1, 1, 3'(i % 5), 3'd4, 1, 0, 0, "rr_all");
    end

`ifdef OPA_PKT_LOCK_EN
    // Locked on S: other requests ignored while S is empty, then S resumes.
    do_reset();
    cyc(0, 5'b00010, 1, 1, 3'd1, 3'd4, 1, 0, 0, "lock_s0");
    cyc(0, 5'b00010, 1, 1, 3'd1, 3'd4, 1, 1, 0, "lock_s1");
    cyc(0, 5'b00001, 0, 0, 3'd7, 3'd4, 1, 1, 0, "lock_stall0");
    cyc(0, 5'b00001, 0, 0, 3'd7, 3'd4, 1, 1, 0, "lock_stall1");
    cyc(0, 5'b00011, 1, 1, 3'd1, 3'd4, 1, 1, 0, "lock_s2");
    cyc(0, 5'b00011, 1, 1, 3'd1, 3'd4, 1, 1, 0, "lock_s3");
    cyc(0, 5'b00011, 1, 1, 3'd0, 3'd4, 1, 0, 0, "after_lock_n");
`endif

    // Credit arriving at zero count: no fire that cycle, fire next cycle.
    do_reset();
    cyc(0, 5'b00010, 0, 1, 3'd1, 3'd4, 1, 0,    0, "zc_a");
    cyc(0, 5'b00010, 0, 1, 3'd1, 3'd3, 1, LOCK, 0, "zc_b");
    cyc(0, 5'b00010, 0, 1, 3'd1, 3'd2, 1, LOCK, 0, "zc_c");
    cyc(0, 5'b00010, 0, 1, 3'd1, 3'd1, 1, LOCK, 0, "zc_d");
    cyc(0, 5'b00010, 1, 0, 3'd7, 3'd0, 1, 0,    0, "zc_credit");
    cyc(0, 5'b00010, 0, 1, 3'd1, 3'd1, 1, 0,    0, "zc_fire");
    cyc(0, 5'b00010, 0, 0, 3'd7, 3'd0, 1, LOCK, 0, "zc_empty");

    // Credit overflow while idle and full: sticky error until reset.
    do_reset();
    cyc(0, 5'b00000, 1, 0, 3'd7, 3'd4, 1, 0, 0, "ovf_pulse");
    cyc(0, 5'b00000, 0, 0, 3'd7, 3'd4, 1, 0, 1, "ovf_set");
    cyc(0, 5'b00000, 0, 0, 3'd7, 3'd4, 1, 0, 1, "ovf_hold0");
    cyc(0, 5'b00000, 0, 0, 3'd7, 3'd4, 1, 0, 1, "ovf_hold1");
    cyc(1, 5'b00000, 0, 0, 3'd7, 3'd4, 1, 0, 1, "ovf_rst");
    cyc(0, 5'b00000, 0, 0, 3'd7, 3'd4, 1, 0, 0, "ovf_cleared");

    // Reset mid-packet on S: next grant goes to N with full credits.
    do_reset();
    cyc(0, 5'b00010, 0, 1, 3'd1, 3'd4, 1, 0,    0, "mid_s0");
    cyc(0, 5'b00010, 0, 1, 3'd1, 3'd3, 1, LOCK, 0, "mid_s1");
    cyc(1, 5'b00011, 0, 0, 3'd7, 3'd2, 1, 0,    0, "mid_rst");
    cyc(0, 5'b00011, 0, 1, 3'd0, 3'd4, 1, 0,    0, "mid_after_n");

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
